// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, default line timings and a
// debug view, used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  // 100 us inhibit and 15 ms transfer limit at a 50 MHz system clock.
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  typedef enum logic [2:0] {
    PS2_IDLE      = 3'd0,
    PS2_INHIBIT   = 3'd1,
    PS2_RTS       = 3'd2,
    PS2_BITS      = 3'd3,
    PS2_ACK       = 3'd4,
    PS2_WAIT_IDLE = 3'd5
  } ps2_state_e;

  typedef struct packed {
    ps2_state_e state;
    logic [3:0] bit_cnt;
    logic       clk_fall;
    logic       data_fall;
  } ps2_host_dbg_t;

  function automatic int ps2_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus a registered falling-edge
// detector; everything resets to the idle (high) line level.
module ps2_sync (
  input  logic clk,
  input  logic resetn,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       old_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      old_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      old_q  <= sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = old_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte plus odd parity on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output logic          done,
  output logic          err,
  output ps2_host_dbg_t dbg_o
);

  localparam int CNT_MAX = ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync, clk_fall, data_sync, data_fall;

  ps2_sync u_sync_clk (
    .clk    (clk),
    .resetn (resetn),
    .line_i (ps2_clk),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_sync u_sync_data (
    .clk    (clk),
    .resetn (resetn),
    .line_i (ps2_data),
    .sync_o (data_sync),
    .fall_o (data_fall)
  );

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timed;

  // Handshake: a byte transfers on a cycle with tx_valid && tx_ready; tx_ready
  // is high only in IDLE, so tx_valid during a transfer is simply dropped.
  assign tx_ready = (state_q == PS2_IDLE);
  assign timed    = (state_q == PS2_RTS) || (state_q == PS2_BITS) || (state_q == PS2_ACK);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      PS2_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          clk_oe_d = 1'b1;
          state_d  = PS2_INHIBIT;
        end
      end
      PS2_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = PS2_RTS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PS2_RTS: state_d = PS2_BITS;
      PS2_BITS: begin
        // Edges 1..8 put data LSB first, edge 9 parity, edge 10 frees the stop bit.
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = PS2_ACK;
          end
        end
      end
      PS2_ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = PS2_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = PS2_IDLE;
          end
        end
      end
      PS2_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = PS2_IDLE;
        end
      end
      default: state_d = PS2_IDLE;
    endcase

    // The transfer watchdog runs from RTS until the ACK edge and overrides all else.
    if (timed) begin
      if (cnt_q == TO_LAST) begin
        state_d   = PS2_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= PS2_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_o       = '{state: state_q, bit_cnt: bit_cnt_q, clk_fall: clk_fall, data_fall: data_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain line model, a behavioural keyboard that
// clocks frames in, a frame-level expected queue and a per-cycle output check.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  typedef enum {M_IDLE, M_BUSY, M_SETTLE} m_phase_e;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready, ps2_clk_oe, ps2_data_oe, done, err;
  logic          ps2_clk, ps2_data;
  logic          kb_clk_low = 1'b0;
  logic          kb_data_low = 1'b0;
  ps2_host_dbg_t dbg;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            acc_cyc = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;
  int            err_cyc = 0;
  m_phase_e      m_phase = M_SETTLE;
  logic [9:0]    exp_q[$];
  logic [9:0]    frame;
  logic [9:0]    tmp;
  bit            ok;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err         (err),
    .dbg_o       (dbg)
  );

  // Open-drain bus: either side pulling low wins, otherwise pulled up.
  assign ps2_clk  = ~(ps2_clk_oe | kb_clk_low);
  assign ps2_data = ~(ps2_data_oe | kb_data_low);

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the keyboard sees it: {stop, odd parity, data}.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (resetn) begin
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      check("done_and_err", {31'd0, done & err}, 32'd0);
      if (m_phase == M_IDLE) begin
        check("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("idle_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("idle_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);
      end else if (m_phase == M_BUSY) begin
        check("busy_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("busy_done", {31'd0, done}, 32'd0);
        check("busy_err", {31'd0, err}, 32'd0);
        if (cyc - acc_cyc < INH) begin
          check("inhibit_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
          check("inhibit_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        end else begin
          check("released_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
          if (cyc - acc_cyc == INH) check("rts_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    m_phase = M_BUSY;
    exp_q.push_back(model_frame(b));
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard: wait for request-to-send, clock 10 bits in (sampled on the rising
  // edge), then ACK by pulling data low (or not) across an 11th clock pulse.
  task automatic kb_frame(input bit ack_low, input int abort_at,
                          output logic [9:0] fr, output bit fin);
    int n = 0;
    fr  = '0;
    fin = 1'b0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", {31'd0, n < 200}, 32'd1);
    if (n >= 200) return;
    for (int i = 0; i < 10; i++) begin
      repeat (HALF) @(negedge clk);
      kb_clk_low = 1'b1;
      if (i + 1 == abort_at) begin
        repeat (HALF / 2) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      kb_clk_low = 1'b0;
      fr[i] = ps2_data;
    end
    m_phase = M_SETTLE;
    repeat (HALF / 2) @(negedge clk);
    kb_data_low = ack_low;
    repeat (HALF / 2) @(negedge clk);
    kb_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    kb_clk_low  = 1'b0;
    kb_data_low = 1'b0;
    fin = 1'b1;
  endtask

  task automatic settle_idle();
    repeat (20) @(negedge clk);
    m_phase = M_IDLE;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int d0, e0, n, rts_cyc;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {29'd0, dbg.state}, {29'd0, PS2_IDLE});
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    m_phase = M_IDLE;

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    kb_frame(1'b1, 0, frame, ok);
    settle_idle();
    check("ed_frame_literal", {22'd0, frame}, {22'd0, 10'h3ED});
    tmp = exp_q.pop_front();
    check("ed_frame_model", {22'd0, frame}, {22'd0, tmp});
    check("ed_done_pulses", done_cnt - d0, 1);
    check("ed_err_pulses", err_cnt - e0, 0);
    check("ed_ready_back", {31'd0, tx_ready}, 32'd1);

    // 0x01 with ACK: even parity bit 0
    d0 = done_cnt; e0 = err_cnt;
    send(8'h01);
    kb_frame(1'b1, 0, frame, ok);
    settle_idle();
    check("x01_frame_literal", {22'd0, frame}, {22'd0, 10'h201});
    tmp = exp_q.pop_front();
    check("x01_frame_model", {22'd0, frame}, {22'd0, tmp});
    check("x01_done_pulses", done_cnt - d0, 1);
    check("x01_err_pulses", err_cnt - e0, 0);

    // NACK: keyboard leaves data high at the ACK edge
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C);
    kb_frame(1'b0, 0, frame, ok);
    settle_idle();
    tmp = exp_q.pop_front();
    check("nack_frame_model", {22'd0, frame}, {22'd0, tmp});
    check("nack_err_pulses", err_cnt - e0, 1);
    check("nack_done_pulses", done_cnt - d0, 0);
    check("nack_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("nack_data_oe", {31'd0, ps2_data_oe}, 32'd0);

    // Timeout: keyboard never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h7E);
    tmp = exp_q.pop_front();
    rts_cyc = acc_cyc + INH;
    while (cyc < rts_cyc + TO - 3) @(negedge clk);
    m_phase = M_SETTLE;
    n = 0;
    while (err_cnt == e0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_err_cycle", err_cyc - rts_cyc, TO);
    check("to_done_pulses", done_cnt - d0, 0);
    check("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    settle_idle();

    // Reset after device edge 5, then a clean 0xF4
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    kb_frame(1'b1, 5, frame, ok);
    check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    m_phase = M_SETTLE;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("arst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("arst_done_err", {30'd0, done, err}, 32'd0);
    tmp = exp_q.pop_front();
    kb_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_no_err", err_cnt - e0, 0);
    m_phase = M_IDLE;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    kb_frame(1'b1, 0, frame, ok);
    settle_idle();
    check("f4_frame_literal", {22'd0, frame}, {22'd0, 10'h2F4});
    tmp = exp_q.pop_front();
    check("f4_frame_model", {22'd0, frame}, {22'd0, tmp});
    check("f4_done_pulses", done_cnt - d0, 1);
    check("f4_err_pulses", err_cnt - e0, 0);

    // tx_valid with 0x55 during a 0xED transfer must be dropped
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    fork
      kb_frame(1'b1, 0, frame, ok);
      begin
        repeat (8) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (60) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00;
      end
    join
    settle_idle();
    check("ign_frame_literal", {22'd0, frame}, {22'd0, 10'h3ED});
    tmp = exp_q.pop_front();
    check("ign_frame_model", {22'd0, frame}, {22'd0, tmp});
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_err_pulses", err_cnt - e0, 0);
    repeat (100) @(negedge clk);
    check("ign_no_second_done", done_cnt - d0, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low before the request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles from clock release to end of ACK (15 ms).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8, command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid, input, 1, request to send tx_data.
REQ-007 SHALL have port tx_ready, output, 1, high in IDLE only.
REQ-008 SHALL have ports ps2_clk and ps2_data, input, 1 each, the raw line levels.
REQ-009 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each; 1 = drive the line low, 0 = release it (open-drain).
REQ-010 SHALL have port done, output, 1, one-cycle pulse on an ACKed transfer.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on a NACK or timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; a falling edge is synchronized-old=1 and synchronized-new=0.
REQ-013 SHALL accept a byte when tx_valid && tx_ready, latching tx_data plus odd parity (~^tx_data) in the same cycle.
REQ-014 SHALL use states IDLE -> INHIBIT -> RTS -> BITS -> ACK -> WAIT_IDLE -> IDLE.
REQ-015 INHIBIT SHALL assert ps2_clk_oe for exactly INHIBIT_CYCLES cycles, with ps2_data_oe low.
REQ-016 RTS SHALL last one cycle: assert ps2_data_oe (start bit 0) and deassert ps2_clk_oe, then enter BITS.
REQ-017 In BITS, device falling edges 1..8 SHALL set ps2_data_oe = ~data[k-1] (LSB first), edge 9 SHALL set ps2_data_oe = ~parity, and edge 10 SHALL release ps2_data_oe (stop bit) and enter ACK.
REQ-018 ACK SHALL sample synchronized ps2_data on the next falling edge: 0 -> WAIT_IDLE; 1 -> err pulse, IDLE.
REQ-019 WAIT_IDLE SHALL wait until synchronized ps2_clk and ps2_data are both 1, then pulse done and enter IDLE.
REQ-020 A timeout counter SHALL start at RTS; if it reaches TIMEOUT_CYCLES before ACK completes, the block SHALL release both lines, pulse err, and enter IDLE.
REQ-021 done and err SHALL never assert in the same cycle.
REQ-022 tx_valid outside IDLE SHALL be ignored; the latched byte SHALL not change during a transfer.
REQ-023 Falling edges seen in IDLE or INHIBIT SHALL be ignored.
REQ-024 The counter width SHALL be $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) and SHALL not wrap.

Reset
REQ-025 resetn low SHALL immediately force IDLE and drive ps2_clk_oe=0, ps2_data_oe=0, done=0, err=0, tx_ready=1, counters=0, synchronizers=1.
REQ-026 A reset mid-transfer SHALL abort with no done or err pulse.

Structure
REQ-027 Package ps2_pkg SHALL hold the state enum and the default INHIBIT/TIMEOUT constants, shared with the keyboard receiver.
REQ-028 One sub-module, ps2_sync (2-flop synchronizer plus falling-edge detect), SHALL be instantiated once per line.

Verification (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, behavioural keyboard model)
REQ-029 Send 0xED with model ACK -> bits sampled 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; tx_ready returns high.
REQ-030 Send 0x01 -> parity 0; ps2_clk_oe high for exactly 20 cycles before ps2_data_oe rises.
REQ-031 Model leaves data high at ACK -> single err pulse, no done, both oe low.
REQ-032 Model never clocks -> err exactly 2000 cycles after RTS, both lines released.
REQ-033 resetn low after edge 5 -> oe outputs 0 asynchronously, no done/err; next 0xF4 transfer completes normally.
REQ-034 tx_valid pulsed with 0x55 during a 0xED transfer -> ignored; the model receives only 0xED.
